// File: rtl/lcd_cmd_sched.sv
// Command scheduler in front of LCD_CTRL: queues host commands, issues them
// one at a time honouring busy, and pulses job_done when a job fully retires.
module lcd_cmd_sched #(
    parameter int               DEPTH     = 4,
    parameter int               CMD_W     = 4,
    parameter logic [CMD_W-1:0] WRITE_CMD = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CMD_W-1:0]         host_cmd,
    input  logic                     host_last,
    input  logic                     host_valid,
    output logic                     host_ready,
    output logic [CMD_W-1:0]         lcd_cmd,
    output logic                     lcd_cmd_valid,
    input  logic                     lcd_busy,
    input  logic                     lcd_done,
    output logic                     job_done,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        HOLD,
        WAIT_IDLE,
        WAIT_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CMD_W:0]   mem_q [DEPTH];
    logic [CMD_W:0]   mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             last_q, last_d;
    logic             push, pop;
    logic [CMD_W:0]   head;

    assign host_ready    = (count_q < (AW+1)'(DEPTH));
    assign push          = host_valid && host_ready;
    assign pop           = (state_q == ISSUE);
    assign head          = mem_q[rd_ptr_q];
    assign lcd_cmd       = cmd_q;
    assign lcd_cmd_valid = valid_q;
    assign job_done      = done_q;
    assign fifo_count    = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {host_last, host_cmd};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // cmd_q doubles as the latched opcode of the command in flight
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        last_d  = last_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0 && !lcd_busy) begin
                    state_d = ISSUE;
                    valid_d = 1'b1;
                    cmd_d   = head[CMD_W-1:0];
                    last_d  = head[CMD_W];
                end
            end
            ISSUE: state_d = HOLD;
            HOLD:  state_d = WAIT_IDLE;
            WAIT_IDLE: begin
                if (!lcd_busy) begin
                    if (last_q && cmd_q == WRITE_CMD) begin
                        state_d = WAIT_DONE;
                    end else begin
                        state_d = IDLE;
                        done_d  = last_q;
                    end
                end
            end
            WAIT_DONE: begin
                if (lcd_done) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cmd_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            last_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cmd_q    <= cmd_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            last_q   <= last_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule
